// File: rtl/ysyx_25030081_pkg.sv
// Shared definitions for the ysyx_25030081 instruction fetch unit.
//   ifu_state_e  : fetch FSM states (FETCH -> WAIT -> DELIVER)
//   IFU_RESET_PC : first fetch address after reset
//   INST_NOP     : instruction substituted for a faulted fetch (addi x0,x0,0)
package ysyx_25030081_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DELIVER = 2'd2
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

endpackage

// File: rtl/ysyx_25030081_ifu.sv
// Instruction fetch unit: issues one fetch at a time to instruction memory,
// holds the returned word until decode accepts it, and follows redirects
// from execute.
//
// Ports
//   clk, rst_n                      : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       : fetch request channel
//   imem_resp_valid/data/err        : fetch response channel (err = access fault)
//   id_valid/ready/inst/pc/fault    : instruction handed to decode
//   redirect_valid/pc               : execute-stage redirect (highest priority)
module ysyx_25030081_ifu
  import ysyx_25030081_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(IFU_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  imem_resp_err,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_inst,
  output logic [DATA_WIDTH-1:0] id_pc,
  output logic                  id_fault,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc
);

  ifu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] ipc_q, ipc_d;
  logic                  fault_q, fault_d;
  logic                  req_fire;

  // The request is masked while reset is held so that nothing is issued
  // during reset, yet it appears in the very first cycle after release.
  assign imem_req_valid = rst_n & (state_q == ST_FETCH);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A redirect kills the held instruction combinationally, so decode can
  // never handshake a wrong-path word even with id_ready high.
  assign id_valid = (state_q == ST_DELIVER) & ~redirect_valid;
  assign id_inst  = inst_q;
  assign id_pc    = ipc_q;
  assign id_fault = fault_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    fault_d = fault_q;

    unique case (state_q)
      ST_FETCH: begin
        if (req_fire) begin
          state_d = ST_WAIT;
          // Request already accepted for the old path: its response is stale.
          drop_d  = redirect_valid;
        end
      end

      ST_WAIT: begin
        if (imem_resp_valid) begin
          if (drop_q || redirect_valid) begin
            state_d = ST_FETCH;
            drop_d  = 1'b0;
          end else begin
            state_d = ST_DELIVER;
            inst_d  = imem_resp_err ? DATA_WIDTH'(INST_NOP) : imem_resp_data;
            ipc_d   = pc_q;
            fault_d = imem_resp_err;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end

      ST_DELIVER: begin
        if (redirect_valid) begin
          state_d = ST_FETCH;
        end else if (id_ready) begin
          state_d = ST_FETCH;
          pc_d    = pc_q + DATA_WIDTH'(3'd4);
        end
      end

      default: state_d = ST_FETCH;
    endcase

    if (redirect_valid) begin
      pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25030081_ifu.sv
module tb_ysyx_25030081_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ysyx_25030081_ifu #(.DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_fault       (id_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------
  // Reference model + scoreboard. Architectural view: the fetch pc
  // only moves on a redirect or an accepted delivery; an accepted
  // request is answered by the next response unless a redirect was
  // seen in between; each answered request yields exactly one
  // delivery of {pc, data or NOP, err}.
  // ---------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pc_exp;
  logic        out_v;
  logic        out_stale;
  logic [31:0] out_pc;
  logic        hold;
  logic [31:0] hold_inst, hold_pc;
  logic        hold_fault;
  int          req_cnt    = 0;
  int          deliveries = 0;

  initial begin
    pc_exp = RST_PC; out_v = 1'b0; out_stale = 1'b0; out_pc = '0; hold = 1'b0;
    hold_inst = '0; hold_pc = '0; hold_fault = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pc_exp = RST_PC;
      exp_q.delete();
      out_v  = 1'b0;
      hold   = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_inst",  id_inst,  hold_inst);
        chk("hold_pc",    id_pc,    hold_pc);
        chk("hold_fault", id_fault, hold_fault);
      end
      if (id_valid) chk("valid_excl_req", imem_req_valid, 1'b0);

      if (imem_resp_valid && out_v) begin
        if (!out_stale && !redirect_valid)
          exp_q.push_back('{pc: out_pc, inst: (imem_resp_err ? NOP : imem_resp_data),
                            fault: imem_resp_err});
        out_v = 1'b0;
      end
      if (redirect_valid && out_v) out_stale = 1'b1;

      if (imem_req_valid && imem_req_ready) begin
        if (!redirect_valid) chk("req_addr", imem_req_addr, pc_exp);
        out_v     = 1'b1;
        out_stale = redirect_valid;
        out_pc    = pc_exp;
        req_cnt++;
      end

      if (redirect_valid) begin
        chk("redirect_kills_valid", id_valid, 1'b0);
        exp_q.delete();
        pc_exp = redirect_pc;
      end else if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_delivery", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("id_pc",    id_pc,    e.pc);
          chk("id_inst",  id_inst,  e.inst);
          chk("id_fault", id_fault, e.fault);
        end
        deliveries++;
        pc_exp = pc_exp + 32'd4;
      end

      hold       = id_valid && !id_ready && !redirect_valid;
      hold_inst  = id_inst;
      hold_pc    = id_pc;
      hold_fault = id_fault;
    end
  end

  // ---------------------------------------------------------------
  // Randomised environment: memory with 0..3 cycle latency, random
  // back-pressure, stray responses, random redirects.
  // ---------------------------------------------------------------
  logic auto_en = 1'b0;
  int   seen_cnt = 0;
  logic have = 1'b0;
  int   lat = 0;

  always begin
    @(posedge clk);
    #1;
    if (!auto_en) begin
      seen_cnt = req_cnt;
      have     = 1'b0;
    end else begin
      if (!rst_n) begin
        have     = 1'b0;
        seen_cnt = req_cnt;
      end else if (req_cnt != seen_cnt) begin
        seen_cnt = req_cnt;
        have     = 1'b1;
        lat      = $urandom_range(0, 3);
      end
      if (have && lat == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = $urandom;
        imem_resp_err   = ($urandom_range(0, 7) == 0);
        have            = 1'b0;
      end else begin
        if (have) lat--;
        imem_resp_valid = !have && ($urandom_range(0, 15) == 0);
        imem_resp_data  = $urandom;
        imem_resp_err   = $urandom_range(0, 1);
      end
      imem_req_ready = ($urandom_range(0, 9) < 7);
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0)
        redirect_pc = 32'hFFFF_FFF8 | (32'($urandom_range(0, 1)) << 2);
      else
        redirect_pc = RST_PC + (32'($urandom_range(0, 255)) << 2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; imem_resp_err = 1'b0;
    id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_id_valid",  id_valid,       1'b0);
    chk("rst_id_inst",   id_inst,        32'h0);
    chk("rst_id_pc",     id_pc,          32'h0);
    chk("rst_id_fault",  id_fault,       1'b0);

    rst_n = 1'b1;
    #1;
    chk("first_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr",  imem_req_addr,  32'h8000_0000);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00A0_0093; imem_resp_err = 1'b0;
    #1;
    chk("wait_req_valid", imem_req_valid, 1'b0);
    step();
    imem_resp_valid = 1'b0;
    #1;
    chk("dlv_valid", id_valid, 1'b1);
    chk("dlv_pc",    id_pc,    32'h8000_0000);
    chk("dlv_inst",  id_inst,  32'h00A0_0093);
    chk("dlv_fault", id_fault, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", id_valid,       1'b1);
      chk("stall_inst",  id_inst,        32'h00A0_0093);
      chk("stall_pc",    id_pc,          32'h8000_0000);
      chk("stall_noreq", imem_req_valid, 1'b0);
    end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    #1;
    chk("next_req_valid", imem_req_valid, 1'b1);
    chk("next_req_addr",  imem_req_addr,  32'h8000_0004);

    // Redirect while waiting; late response must be dropped.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
    step();
    imem_resp_valid = 1'b0;
    #1;
    chk("drop_req_valid", imem_req_valid, 1'b1);
    chk("drop_req_addr",  imem_req_addr,  32'h8000_0100);
    chk("drop_no_valid",  id_valid,       1'b0);

    // Redirect coincident with id_ready in DELIVER.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0073;
    step();
    imem_resp_valid = 1'b0;
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    #1;
    chk("rdj_no_valid", id_valid, 1'b0);
    step();
    redirect_valid = 1'b0; id_ready = 1'b0;
    #1;
    chk("rdj_req_addr", imem_req_addr, 32'h8000_0200);

    // Access fault becomes a NOP with id_fault set.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF; imem_resp_err = 1'b1;
    step();
    imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
    #1;
    chk("err_fault", id_fault, 1'b1);
    chk("err_inst",  id_inst,  32'h0000_0013);
    chk("err_pc",    id_pc,    32'h8000_0200);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    #1;
    chk("err_next_addr", imem_req_addr, 32'h8000_0204);

    // pc wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_start_addr", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0513;
    step();
    imem_resp_valid = 1'b0;
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    #1;
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);

    // Randomised phase with one reset in the middle of traffic.
    auto_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      if (c == 2000) begin #3; rst_n = 1'b0; end
      if (c == 2003) begin #3; rst_n = 1'b1; end
    end
    auto_en = 1'b0;
    @(posedge clk);
    #1;
    chk("progress", (deliveries >= 200), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
